// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the CPU instruction-fetch and data ports.
// One access is in flight at a time: IDLE -> GRANT -> (WAIT -> RESP) -> IDLE.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MEM_LAT  = 1,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_cs,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e            state_q;
    logic              owner_q;
    logic              last_gnt_q;
    logic [1:0]        cnt_q;
    logic              i_gnt_q;
    logic              i_rvalid_q;
    logic [31:0]       i_rdata_q;
    logic              d_gnt_q;
    logic              d_rvalid_q;
    logic [31:0]       d_rdata_q;
    logic              mem_cs_q;
    logic [3:0]        mem_we_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              busy_q;
    logic              win_d;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    // Winner of the IDLE-cycle arbitration; 1 selects the data port.
    always_comb begin
        win_d = 1'b0;
        if (d_req && !i_req) begin
            win_d = 1'b1;
        end else if (d_req && i_req) begin
            win_d = (ARB_MODE == 1) ? 1'b1 : !last_gnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_gnt_q  <= 1'b1;
            cnt_q       <= 2'd0;
            i_gnt_q     <= 1'b0;
            i_rvalid_q  <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_gnt_q     <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= 32'd0;
            mem_cs_q    <= 1'b0;
            mem_we_q    <= 4'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_we_q   <= 4'd0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_q     <= GRANT;
                        busy_q      <= 1'b1;
                        owner_q     <= win_d;
                        mem_cs_q    <= 1'b1;
                        i_gnt_q     <= !win_d;
                        d_gnt_q     <= win_d;
                        mem_addr_q  <= win_d ? d_addr[ADDR_W-1:2] : i_addr[ADDR_W-1:2];
                        mem_we_q    <= win_d ? d_we : 4'd0;
                        mem_wdata_q <= win_d ? d_wdata : 32'd0;
                    end
                end
                GRANT: begin
                    last_gnt_q <= owner_q;
                    // Only a data-port write ever has a nonzero strobe here.
                    if (mem_we_q != 4'd0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= RESP;
                        if (owner_q) begin
                            d_rdata_q  <= mem_rdata;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            i_rdata_q  <= mem_rdata;
                            i_rvalid_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign i_gnt     = i_gnt_q;
    assign i_rvalid  = i_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_gnt     = d_gnt_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin/latency-1 instance, fixed-priority instance
// and latency-3 instance driven from shared request inputs.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rstL_n;
    logic        iReq;
    logic [31:0] iAddr;
    logic        dReq;
    logic [3:0]  dWe;
    logic [31:0] dAddr;
    logic [31:0] dWdata;

    logic        iGntA, iRvalidA, dGntA, dRvalidA, memCsA, busyA;
    logic [31:0] iRdataA, dRdataA, memWdataA, memRdataA;
    logic [3:0]  memWeA;
    logic [29:0] memAddrA;

    logic        iGntP, iRvalidP, dGntP, dRvalidP, memCsP, busyP;
    logic [31:0] iRdataP, dRdataP, memWdataP;
    logic [3:0]  memWeP;
    logic [29:0] memAddrP;

    logic        iGntL, iRvalidL, dGntL, dRvalidL, memCsL, busyL;
    logic [31:0] iRdataL, dRdataL, memWdataL, memRdataL;
    logic [3:0]  memWeL;
    logic [29:0] memAddrL;

    logic [31:0] mem [0:63];
    logic [31:0] pipeL [0:2];

    int nChecks = 0;
    int nBad    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .MEM_LAT(1), .ARB_MODE(0)) dutA (
        .clk(clk), .rst_n(rst_n),
        .i_req(iReq), .i_addr(iAddr), .i_gnt(iGntA), .i_rvalid(iRvalidA), .i_rdata(iRdataA),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_gnt(dGntA), .d_rvalid(dRvalidA), .d_rdata(dRdataA),
        .mem_cs(memCsA), .mem_we(memWeA), .mem_addr(memAddrA), .mem_wdata(memWdataA),
        .mem_rdata(memRdataA), .busy(busyA)
    );

    mem_arbiter #(.ADDR_W(32), .MEM_LAT(1), .ARB_MODE(1)) dutP (
        .clk(clk), .rst_n(rst_n),
        .i_req(iReq), .i_addr(iAddr), .i_gnt(iGntP), .i_rvalid(iRvalidP), .i_rdata(iRdataP),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_gnt(dGntP), .d_rvalid(dRvalidP), .d_rdata(dRdataP),
        .mem_cs(memCsP), .mem_we(memWeP), .mem_addr(memAddrP), .mem_wdata(memWdataP),
        .mem_rdata(memRdataA), .busy(busyP)
    );

    mem_arbiter #(.ADDR_W(32), .MEM_LAT(3), .ARB_MODE(0)) dutL (
        .clk(clk), .rst_n(rstL_n),
        .i_req(iReq), .i_addr(iAddr), .i_gnt(iGntL), .i_rvalid(iRvalidL), .i_rdata(iRdataL),
        .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
        .d_gnt(dGntL), .d_rvalid(dRvalidL), .d_rdata(dRdataL),
        .mem_cs(memCsL), .mem_we(memWeL), .mem_addr(memAddrL), .mem_wdata(memWdataL),
        .mem_rdata(memRdataL), .busy(busyL)
    );

    // SRAM model: preloaded while rst_n is low; only dutA may write. Data is poisoned
    // outside the latency window so a mistimed capture shows up as a wrong value.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= 32'hA500_0000 | 32'(i);
            end
            mem[4] <= 32'h0050_0093;
            memRdataA <= 32'hBAD0_BAD0;
        end else if (memCsA) begin
            for (int b = 0; b < 4; b++) begin
                if (memWeA[b]) mem[memAddrA[5:0]][8*b +: 8] <= memWdataA[8*b +: 8];
            end
            memRdataA <= mem[memAddrA[5:0]];
        end else begin
            memRdataA <= 32'hBAD0_BAD0;
        end
    end

    always @(posedge clk) begin
        pipeL[0] <= memCsL ? mem[memAddrL[5:0]] : 32'hBAD0_BAD0;
        pipeL[1] <= pipeL[0];
        pipeL[2] <= pipeL[1];
    end
    assign memRdataL = pipeL[2];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        iReq   = ir;
        iAddr  = ia;
        dReq   = dr;
        dWe    = dw;
        dAddr  = da;
        dWdata = dd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetAll();
        rst_n  = 1'b0;
        rstL_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        rst_n  = 1'b1;
        rstL_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bothCnt;
        int iCntP;
        int dCntP;
        int quietCnt;
        logic [1:0] expGnt;

        // Reset held with busy inputs: every output stays at zero.
        rst_n  = 1'b0;
        rstL_n = 1'b0;
        applyStimulus(1, 32'h10, 1, 4'hf, 32'h20, 32'hFFFF_FFFF);
        nextCycle();
        applyStimulus(0, 32'hFC, 1, 4'h0, 32'h44, 32'h1234_5678);
        nextCycle();
        applyStimulus(1, 32'h04, 0, 4'h5, 32'h08, 32'h0);
        nextCycle();
        checkOutput("rst_ctrl", {iGntA, iRvalidA, dGntA, dRvalidA, memCsA, memWeA, busyA}, 0);
        checkOutput("rst_addr", {2'b0, memAddrA}, 0);
        checkOutput("rst_wdata", memWdataA, 0);
        checkOutput("rst_rdata", iRdataA | dRdataA, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rst_n  = 1'b1;
        rstL_n = 1'b1;
        nextCycle();
        nextCycle();
        checkOutput("post_rst_ctrl", {iGntA, iRvalidA, dGntA, dRvalidA, memCsA, memWeA, busyA}, 0);

        // Latency-1 instruction read of word 4.
        resetAll();
        applyStimulus(1, 32'h10, 0, 0, 0, 0);
        nextCycle();
        checkOutput("i_gnt_c1", {iGntA, dGntA, memCsA, busyA}, 4'b1011);
        checkOutput("i_addr_c1", {2'b0, memAddrA}, 32'h4);
        checkOutput("i_we_c1", {28'd0, memWeA}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("i_c2", {iGntA, memCsA, iRvalidA}, 0);
        nextCycle();
        checkOutput("i_rvalid_c3", {iRvalidA, dRvalidA}, 2'b10);
        checkOutput("i_rdata_c3", iRdataA, 32'h0050_0093);
        nextCycle();
        checkOutput("i_c4", {iRvalidA, busyA}, 0);
        checkOutput("i_rdata_hold", iRdataA, 32'h0050_0093);

        // Data write, read-back, then a partial-strobe write.
        resetAll();
        applyStimulus(0, 0, 1, 4'hf, 32'h20, 32'hDEAD_BEEF);
        nextCycle();
        checkOutput("w_gnt_c1", {iGntA, dGntA, memCsA}, 3'b011);
        checkOutput("w_we_c1", {28'd0, memWeA}, 32'hf);
        checkOutput("w_addr_c1", {2'b0, memAddrA}, 32'h8);
        checkOutput("w_wdata_c1", memWdataA, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("w_c2", {dGntA, dRvalidA, memCsA, memWeA, busyA}, 0);
        applyStimulus(0, 0, 1, 4'h0, 32'h20, 0);
        nextCycle();
        checkOutput("r_gnt_c3", {dGntA, dRvalidA, memWeA}, 6'b100000);
        checkOutput("r_addr_c3", {2'b0, memAddrA}, 32'h8);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("r_c4", {28'd0, dRvalidA}, 0);
        nextCycle();
        checkOutput("r_rvalid_c5", {iRvalidA, dRvalidA}, 2'b01);
        checkOutput("r_rdata_c5", dRdataA, 32'hDEAD_BEEF);
        nextCycle();
        applyStimulus(0, 0, 1, 4'h3, 32'h20, 32'h1122_3344);
        nextCycle();
        checkOutput("pw_we", {28'd0, memWeA}, 32'h3);
        checkOutput("pw_wdata", memWdataA, 32'h1122_3344);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1, 4'h0, 32'h20, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        checkOutput("pw_rvalid", {28'd0, dRvalidA}, 1);
        checkOutput("pw_rdata", dRdataA, 32'hDEAD_3344);

        // Both ports held high: round-robin alternates I, D; fixed priority starves I.
        resetAll();
        applyStimulus(1, 32'h10, 1, 4'h0, 32'h20, 0);
        bothCnt = 0;
        iCntP   = 0;
        dCntP   = 0;
        for (int c = 1; c <= 16; c++) begin
            nextCycle();
            expGnt = (c == 1 || c == 9) ? 2'b10 : (c == 5 || c == 13) ? 2'b01 : 2'b00;
            checkOutput($sformatf("rr_gnt_c%0d", c), {30'd0, iGntA, dGntA}, {30'd0, expGnt});
            if ((iGntA && dGntA) || (iGntP && dGntP)) bothCnt++;
            if (iGntP) iCntP++;
            if (dGntP) dCntP++;
        end
        checkOutput("no_double_gnt", bothCnt, 0);
        checkOutput("prio_i_gnts", iCntP, 0);
        checkOutput("prio_d_gnts", dCntP, 4);

        // Latency-3 read, then an access aborted by reset while waiting.
        resetAll();
        applyStimulus(1, 32'h10, 0, 0, 0, 0);
        nextCycle();
        checkOutput("l3_gnt_c1", {31'd0, iGntL}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        nextCycle();
        checkOutput("l3_c4", {31'd0, iRvalidL}, 0);
        nextCycle();
        checkOutput("l3_rvalid_c5", {31'd0, iRvalidL}, 1);
        checkOutput("l3_rdata_c5", iRdataL, 32'h0050_0093);
        nextCycle();
        applyStimulus(1, 32'h10, 0, 0, 0, 0);
        nextCycle();
        checkOutput("ab_gnt", {31'd0, iGntL}, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("ab_busy_wait", {31'd0, busyL}, 1);
        rstL_n = 1'b0;
        #1;
        checkOutput("ab_busy_rst", {31'd0, busyL}, 0);
        nextCycle();
        rstL_n = 1'b1;
        quietCnt = 0;
        for (int c = 0; c < 6; c++) begin
            nextCycle();
            if (iRvalidL || iGntL || dGntL || dRvalidL || busyL) quietCnt++;
        end
        checkOutput("ab_quiet", quietCnt, 0);
        checkOutput("ab_rdata_cleared", iRdataL, 0);
        applyStimulus(1, 32'h10, 1, 4'h0, 32'h20, 0);
        nextCycle();
        checkOutput("ab_tie_gnt", {30'd0, iGntL, dGntL}, 2'b10);
        applyStimulus(0, 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
